// File: rtl/reg_file_sb.sv
// reg_file_sb: general-purpose register file with a per-register busy scoreboard.
// Two combinational read ports and one synchronous write port.
// Issue reserves a destination register, and writeback releases it.
// Optional macro REG_FILE_BYPASS_EN: write data is forwarded to the read ports in the
// same cycle as the write.
module reg_file_sb #(
    parameter int dw    = 8,
    parameter int pw    = 2,
    parameter int ZERO0 = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [pw-1:0]     wr_addr,
    input  logic [dw-1:0]     dat_in,
    input  logic              rsv_en,
    input  logic [pw-1:0]     rsv_addr,
    input  logic [pw-1:0]     rd_addrA,
    input  logic [pw-1:0]     rd_addrB,
    output logic [dw-1:0]     datA_out,
    output logic [dw-1:0]     datB_out,
    output logic              busyA,
    output logic              busyB,
    output logic              rsv_err,
    output logic [2**pw-1:0]  busy_vec
);
    localparam int DEPTH = 2**pw;
    localparam bit Z0    = (ZERO0 != 0);

    logic [dw-1:0]    regs [DEPTH];
    logic [DEPTH-1:0] busy_d;
    logic             wr_take;
    logic             rsv_take;
    logic             retire;
    logic             refused;

    // Register 0 is hard-wired when Z0 is set, so it takes no writes and no reservations.
    always_comb begin
        wr_take  = wr_en  && !(Z0 && wr_addr  == '0);
        rsv_take = rsv_en && !(Z0 && rsv_addr == '0);
        // A write to the same register retires the old reservation on this edge.
        retire   = wr_en && (wr_addr == rsv_addr);
        refused  = rsv_take && busy_vec[rsv_addr] && !retire;
        busy_d   = busy_vec;
        if (wr_en)
            busy_d[wr_addr] = 1'b0;
        if (rsv_take && !refused)
            busy_d[rsv_addr] = 1'b1;
    end

    // Write port for the register array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else if (wr_take) begin
            regs[wr_addr] <= dat_in;
        end
    end

    // Scoreboard update and the one-cycle pulse for a refused reservation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_vec <= '0;
            rsv_err  <= 1'b0;
        end else begin
            busy_vec <= busy_d;
            rsv_err  <= refused;
        end
    end

    // Read port A: the stored value, an optional forwarded write, and the r0 override.
    always_comb begin
        datA_out = regs[rd_addrA];
        busyA    = busy_vec[rd_addrA];
`ifdef REG_FILE_BYPASS_EN
        if (wr_en && wr_addr == rd_addrA) begin
            datA_out = dat_in;
            busyA    = 1'b0;
        end
`endif
        if (Z0 && rd_addrA == '0) begin
            datA_out = '0;
            busyA    = 1'b0;
        end
    end

    // Read port B: the same behaviour as port A.
    always_comb begin
        datB_out = regs[rd_addrB];
        busyB    = busy_vec[rd_addrB];
`ifdef REG_FILE_BYPASS_EN
        if (wr_en && wr_addr == rd_addrB) begin
            datB_out = dat_in;
            busyB    = 1'b0;
        end
`endif
        if (Z0 && rd_addrB == '0) begin
            datB_out = '0;
            busyB    = 1'b0;
        end
    end
endmodule
